fwd_hazard_ctrl: RTL
====================

FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of the stall-cycle performance counter.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 id_valid  input  1  ID stage holds a real instruction.
REQ-005 id_rs, id_rt  input  5 each  source register numbers of the ID instruction.
REQ-006 id_rd  input  5  resolved destination register of the ID instruction.
REQ-007 id_reg_write, id_mem_read  input  1 each  ID instruction writes the register file, or is a load.
REQ-008 flush  input  1  branch taken; squash the ID instruction.
REQ-009 fwd_a, fwd_b  output  2 each  registered select for the EX-stage 3-input operand muxes: 00 register file, 01 WB result, 10 MEM ALU result; 11 never driven.
REQ-010 stall  output  1  hold PC and IF/ID register this cycle.
REQ-011 ex_valid  output  1  EX stage holds a real, non-bubble instruction.
REQ-012 stall_cnt  output  CNT_W  saturating count of stall cycles since reset.

Function
REQ-013 The block SHALL track three internal stage entries: EX, MEM and WB. Each entry holds valid, rd, reg_write and mem_read.
REQ-014 Each rising clk SHALL shift WB<=MEM and MEM<=EX. EX SHALL load from the ID inputs, or load a bubble (valid=0) per REQ-017/REQ-019.
REQ-015 A producer SHALL match a source register only if: the entry is valid, reg_write=1, rd!=0, and rd equals that source.
REQ-016 On the edge that loads ID into EX, next fwd_a SHALL be computed from id_rs as follows, and next fwd_b identically from id_rt:
  - 10 if the current EX entry matches;
  - else 01 if the current MEM entry matches;
  - else 00.
  The nearer producer always wins.
REQ-017 Load-use hazard: id_valid=1, EX valid, EX mem_read=1, EX rd!=0, and EX rd equals id_rs or id_rt.
REQ-018 FSM states are RUN and STALL.
  - RUN to STALL: a load-use hazard is present and flush=0. stall SHALL be combinational 1 in that same cycle.
  - At the edge leaving RUN, EX SHALL load a bubble and fwd_a/fwd_b SHALL be set to 00.
REQ-019 In STALL the block SHALL drive stall=0 and load ID into EX normally. The FSM SHALL return to RUN after exactly one cycle, so the maximum stall is one cycle per load.
REQ-020 After a load-use stall, the dependent instruction SHALL receive select 01, because the load is then in WB.
REQ-021 flush=1 SHALL force a bubble into EX and suppress stall in that cycle; flush has priority over a load-use hazard, and the FSM SHALL stay in or return to RUN.
REQ-022 id_valid=0 SHALL load a bubble into EX and SHALL never cause a stall.
REQ-023 Register 0 SHALL never be forwarded and SHALL never cause a stall.
REQ-024 stall_cnt SHALL increment on each rising edge where stall=1, and SHALL saturate at all-ones without wrapping.
REQ-025 The register file is write-before-read, so WB-to-ID same-cycle hazards are out of scope. Select 11 SHALL never appear.
REQ-026 ex_valid SHALL equal the EX entry valid bit.

Reset
REQ-027 While rst_n=0, asynchronously and regardless of clk:
  - all entries SHALL be invalid;
  - fwd_a=fwd_b=00, stall=0, ex_valid=0;
  - stall_cnt=0 and FSM=RUN.
REQ-028 Reset asserted mid-stall SHALL clear stall immediately. After reset release, the first edge SHALL load ID normally.

Verification
REQ-029 Back-to-back ALU dependency:
  - Stimulus: add rd=5, then sub rs=5 rt=5.
  - Required: sub in EX sees fwd_a=fwd_b=10 and no stall.
REQ-030 Distance-2 dependency and priority:
  - Stimulus: add rd=7, an unrelated instruction, then or rs=7, giving fwd_a=01. Then add rd=7, add rd=7, and a consumer rs=7.
  - Required: fwd_a=10, meaning the nearer producer wins.
REQ-031 Load-use:
  - Stimulus: lw rd=8, then add rs=8.
  - Required: stall=1 for one cycle, and EX shows bubble (ex_valid=0). The add then enters EX with fwd_a=01, and stall_cnt=1.
REQ-032 Register zero:
  - Stimulus: lw rd=0, then add rs=0.
  - Required: stall=0 and fwd_a=00.
REQ-033 Flush during hazard:
  - Stimulus: lw rd=9, then add rs=9 with flush=1 in the same cycle.
  - Required: stall=0, an EX bubble, FSM in RUN, and stall_cnt unchanged.
REQ-034 Saturation and reset:
  - Stimulus: with CNT_W=2, force 5 stalls; then pulse rst_n low between edges.
  - Required: stall_cnt reads 3 after the stalls. On the reset pulse, all outputs clear immediately and stall_cnt=0.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard controller for a 5-stage in-order pipeline.
// Latency: fwd_a/fwd_b/ex_valid registered (1 cycle after ID); stall is combinational.
// Backpressure: stall holds PC and IF/ID for exactly one cycle per load-use; flush overrides it.
module fwd_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic [4:0]       id_rd,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             stall,
   output logic             ex_valid,
   output logic [CNT_W-1:0] stall_cnt
);

   // One pipeline stage's view of its instruction, as far as hazards are concerned.
   typedef struct packed {
      logic       vld;
      logic [4:0] rd;
      logic       rw;
      logic       mr;
   } stage_t;

   typedef enum logic {
      S_RUN   = 1'b0,
      S_STALL = 1'b1
   } state_t;

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_WB  = 2'b01;
   localparam logic [1:0] SEL_MEM = 2'b10;

   stage_t           ex_q, mem_q, wb_q;
   stage_t           ex_d;
   state_t           state_q;
   logic [1:0]       fwd_a_q, fwd_b_q;
   logic [1:0]       fwd_a_d, fwd_b_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             load_use;
   logic             bubble;

   // A stage produces a value for register r only if it really writes a non-zero rd equal to r.
   function automatic logic prod_match(input stage_t s, input logic [4:0] r);
      return s.vld && s.rw && (s.rd != 5'd0) && (s.rd == r);
   endfunction

   // Select is computed one edge early: today's EX will be in MEM, today's MEM in WB.
   function automatic logic [1:0] fwd_sel(input stage_t ex_s, input stage_t mem_s,
                                          input logic [4:0] r);
      if (prod_match(ex_s, r)) begin
         return SEL_MEM;
      end else if (prod_match(mem_s, r)) begin
         return SEL_WB;
      end
      return SEL_RF;
   endfunction

   // Load-use detection and stall; STALL state masks it so a load never stalls twice.
   always_comb begin
      load_use = id_valid && ex_q.vld && ex_q.mr && (ex_q.rd != 5'd0) &&
                 ((ex_q.rd == id_rs) || (ex_q.rd == id_rt));
      stall    = (state_q == S_RUN) && load_use && !flush;
      bubble   = flush || stall || !id_valid;
   end

   // Next EX entry, next operand selects and saturating stall counter.
   always_comb begin
      ex_d        = '0;
      fwd_a_d     = SEL_RF;
      fwd_b_d     = SEL_RF;
      stall_cnt_d = stall_cnt_q;
      if (!bubble) begin
         ex_d.vld = 1'b1;
         ex_d.rd  = id_rd;
         ex_d.rw  = id_reg_write;
         ex_d.mr  = id_mem_read;
         fwd_a_d  = fwd_sel(ex_q, mem_q, id_rs);
         fwd_b_d  = fwd_sel(ex_q, mem_q, id_rt);
      end
      if (stall && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // Pipeline shift, FSM and registered outputs; reset clears everything asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         state_q     <= S_RUN;
         fwd_a_q     <= SEL_RF;
         fwd_b_q     <= SEL_RF;
         stall_cnt_q <= '0;
      end else begin
         wb_q        <= mem_q;
         mem_q       <= ex_q;
         ex_q        <= ex_d;
         fwd_a_q     <= fwd_a_d;
         fwd_b_q     <= fwd_b_d;
         stall_cnt_q <= stall_cnt_d;
         state_q     <= stall ? S_STALL : S_RUN;
      end
   end

   assign fwd_a     = fwd_a_q;
   assign fwd_b     = fwd_b_q;
   assign ex_valid  = ex_q.vld;
   assign stall_cnt = stall_cnt_q;

endmodule
